// File: rtl/agdc_input_cond.sv
// Input conditioner for the garage door controller: synchronises and debounces the
// push-button and limit switches, and produces a one-shot Activate plus a sticky fault.
module agdc_input_cond #(
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic activate_raw,
  input  logic up_max_raw,
  input  logic dn_max_raw,
  output logic activate,
  output logic up_max,
  output logic dn_max,
  output logic sensor_fault
);

  // Channel index: 0 = activate, 1 = up limit, 2 = down limit (door closed at reset).
  localparam logic [2:0]       RST_VAL  = 3'b100;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             act_rise;
  logic             limits_now;
  logic             limits_next;

  assign raw = {dn_max_raw, up_max_raw, activate_raw};

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Terminal-count compare doubles as the clear path, so the counter never wraps.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      stable_q <= RST_VAL;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign act_rise    = ~stable_q[0] & stable_d[0];
  assign limits_now  = stable_q[1] & stable_q[2];
  // Also looks at the next limit levels so a press accepted on the same edge as a fault is dropped.
  assign limits_next = stable_d[1] & stable_d[2];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      activate     <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      activate     <= act_rise & ~sensor_fault & ~limits_now & ~limits_next;
      sensor_fault <= sensor_fault | limits_now;
    end
  end

  assign up_max = stable_q[1];
  assign dn_max = stable_q[2];

endmodule

// File: tb/tb_agdc_input_cond.sv
// Bench for agdc_input_cond: a sliding-window behavioural model checked every cycle,
// plus directed scenarios with hand-computed latencies.
module tb_agdc_input_cond;

  localparam int DEB = 8;

  logic clk_sys = 1'b0;
  logic rst_b;
  logic act_raw, up_raw, dn_raw;
  logic activate, up_max, dn_max, sensor_fault;

  int n_tests = 0;
  int n_fail  = 0;

  agdc_input_cond #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk_sys      (clk_sys),
    .rst_b        (rst_b),
    .activate_raw (act_raw),
    .up_max_raw   (up_raw),
    .dn_max_raw   (dn_raw),
    .activate     (activate),
    .up_max       (up_max),
    .dn_max       (dn_max),
    .sensor_fault (sensor_fault)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: win[c][k] is the raw level sampled k+1 edges ago. A level is accepted
  // when the synchronised value (raw two edges back) has differed from the stable
  // level on each of the last DEB edges.
  bit       win [3][DEB+1];
  bit [2:0] stab  = 3'b100;
  bit       m_act = 1'b0;
  bit       m_sf  = 1'b0;

  always @(posedge clk_sys or negedge rst_b) begin
    bit [2:0] nst;
    bit [2:0] rawv;
    bit       all_diff;
    if (!rst_b) begin
      for (int c = 0; c < 3; c++)
        for (int k = 0; k <= DEB; k++) win[c][k] = (c == 2);
      stab  = 3'b100;
      m_act = 1'b0;
      m_sf  = 1'b0;
    end else begin
      rawv = {dn_raw, up_raw, act_raw};
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (win[c][k] == stab[c]) all_diff = 1'b0;
        nst[c] = all_diff ? win[c][1] : stab[c];
      end
      m_act = !stab[0] && nst[0] && !m_sf && !(stab[1] && stab[2]) && !(nst[1] && nst[2]);
      m_sf  = m_sf || (stab[1] && stab[2]);
      for (int c = 0; c < 3; c++) begin
        for (int k = DEB; k > 0; k--) win[c][k] = win[c][k-1];
        win[c][0] = rawv[c];
      end
      stab = nst;
    end
  end

  always @(negedge clk_sys) begin
    chk("model_activate",     int'(activate),     int'(m_act));
    chk("model_up_max",       int'(up_max),       int'(stab[1]));
    chk("model_dn_max",       int'(dn_max),       int'(stab[2]));
    chk("model_sensor_fault", int'(sensor_fault), int'(m_sf));
  end

  int act_first, act_cnt, up_first, dn_first, sf_first;

  // Hold current raw levels for n edges; record the first cycle each output is high.
  task automatic run(input int n);
    act_first = -1; act_cnt = 0; up_first = -1; dn_first = -1; sf_first = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_sys);
      if (activate) begin
        act_cnt++;
        if (act_first < 0) act_first = i;
      end
      if (up_max && up_first < 0) up_first = i;
      if (dn_max && dn_first < 0) dn_first = i;
      if (sensor_fault && sf_first < 0) sf_first = i;
    end
  endtask

  initial begin
    int total;
    rst_b = 1'b0; act_raw = 1'b0; up_raw = 1'b0; dn_raw = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("reset_activate", int'(activate), 0);
    chk("reset_up_max", int'(up_max), 0);
    chk("reset_dn_max", int'(dn_max), 1);
    chk("reset_sensor_fault", int'(sensor_fault), 0);
    rst_b = 1'b1;
    run(20);

    act_raw = 1'b1; run(20);
    chk("press1_first", act_first, 10);
    chk("press1_count", act_cnt, 1);
    act_raw = 1'b0; run(20);
    chk("release1_count", act_cnt, 0);
    act_raw = 1'b1; run(20);
    chk("press2_first", act_first, 10);
    chk("press2_count", act_cnt, 1);
    act_raw = 1'b0; run(20);

    total = 0;
    for (int p = 0; p < 15; p++) begin
      act_raw = p[0];
      run(2);
      total += act_cnt;
    end
    chk("bounce_count", total, 0);
    act_raw = 1'b1; run(20);
    chk("bounce_hold_first", act_first, 10);
    chk("bounce_hold_count", act_cnt, 1);
    act_raw = 1'b0; run(20);

    up_raw = 1'b1; run(5);
    chk("glitch5_up_a", up_first, -1);
    up_raw = 1'b0; run(15);
    chk("glitch5_up_b", up_first, -1);
    up_raw = 1'b1; run(7);
    chk("glitch7_up_a", up_first, -1);
    up_raw = 1'b0; run(15);
    chk("glitch7_up_b", up_first, -1);

    up_raw = 1'b1; run(12);
    chk("limit_up_first", up_first, 10);
    run(8);
    chk("limit_up_held", int'(up_max), 1);

    dn_raw = 1'b1; run(12);
    chk("fault_dn_first", dn_first, 10);
    chk("fault_sf_first", sf_first, 11);

    act_raw = 1'b1; run(12);
    chk("suppress_count", act_cnt, 0);
    act_raw = 1'b0; run(12);

    up_raw = 1'b0; run(7);
    chk("middeb_up_still_high", int'(up_max), 1);
    #3 rst_b = 1'b0;
    #1;
    chk("async_reset_sf", int'(sensor_fault), 0);
    chk("async_reset_up", int'(up_max), 0);
    chk("async_reset_dn", int'(dn_max), 1);
    chk("async_reset_act", int'(activate), 0);
    @(negedge clk_sys);
    act_raw = 1'b1;
    rst_b = 1'b1;
    run(20);
    chk("post_reset_press_first", act_first, 10);
    chk("post_reset_press_count", act_cnt, 1);
    chk("post_reset_sf", sf_first, -1);
    chk("post_reset_dn_first", dn_first, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
